// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, the I-cache request and the
// IF/ID pipeline register. Redirects from ID take priority JumpR > Jump > PCSrc.
// A redirect that arrives during an I-cache miss is parked in redir_r and the
// stage waits in S_REDIR until the miss completes, then discards the word.
// Optional build macro IF_PERF_CNT_EN adds perf_fetch / perf_bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic        Jump,
  input  logic [25:0] jump_index,
  input  logic        JumpR,
  input  logic [31:0] jr_target,
  input  logic        IF_Flush,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  output logic [31:0] pc,
  output logic [31:0] IFID_inst,
  output logic [31:0] IFID_pc4,
  output logic        IFID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  typedef enum logic {S_RUN = 1'b0, S_REDIR = 1'b1} state_t;
  typedef enum logic [1:0] {OP_HOLD = 2'd0, OP_LOAD = 2'd1, OP_BUBBLE = 2'd2} ifid_op_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s, pc_seq_s;
  logic [31:0] redir_r, redir_nxt_s;
  logic [31:0] target_s;
  logic        redirect_s;
  logic        ren_r;
  ifid_op_t    ifid_op_s;
  logic [31:0] ifid_inst_r, ifid_pc4_r;
  logic        ifid_valid_r;

  // The request address always follows pc; pc is frozen while a miss is pending.
  assign pc          = pc_r;
  assign ICACHE_addr = pc_r[31:2];
  assign ICACHE_ren  = ren_r;
  assign IFID_inst   = ifid_inst_r;
  assign IFID_pc4    = ifid_pc4_r;
  assign IFID_valid  = ifid_valid_r;

  assign pc_seq_s   = pc_r + 32'd4;
  assign redirect_s = JumpR | Jump | PCSrc;

  // Redirect target selection, highest priority first.
  always_comb begin
    target_s = pc_seq_s;
    if (JumpR) begin
      target_s = jr_target;
    end else if (Jump) begin
      target_s = {ifid_pc4_r[31:28], jump_index, 2'b00};
    end else if (PCSrc) begin
      target_s = branch_target;
    end else begin
      target_s = pc_seq_s;
    end
  end

  // Next-state, next-PC and IF/ID update decision.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    redir_nxt_s = redir_r;
    ifid_op_s   = OP_HOLD;
    if (!ren_r) begin
      // First cycle after reset release: request not yet issued, nothing moves.
      ifid_op_s = OP_HOLD;
    end else begin
      case (state_r)
        S_RUN: begin
          if (redirect_s) begin
            ifid_op_s = OP_BUBBLE;
            if (ICACHE_stall) begin
              redir_nxt_s = target_s;
              state_nxt_s = S_REDIR;
            end else begin
              pc_nxt_s = target_s;
            end
          end else if (ICACHE_stall) begin
            ifid_op_s = stall ? OP_HOLD : OP_BUBBLE;
          end else if (stall) begin
            ifid_op_s = OP_HOLD;
          end else if (IF_Flush) begin
            ifid_op_s = OP_BUBBLE;
            pc_nxt_s  = pc_seq_s;
          end else begin
            ifid_op_s = OP_LOAD;
            pc_nxt_s  = pc_seq_s;
          end
        end
        S_REDIR: begin
          ifid_op_s = OP_BUBBLE;
          if (ICACHE_stall) begin
            redir_nxt_s = redirect_s ? target_s : redir_r;
          end else begin
            pc_nxt_s    = redirect_s ? target_s : redir_r;
            state_nxt_s = S_RUN;
          end
        end
        default: begin
          state_nxt_s = S_RUN;
          ifid_op_s   = OP_BUBBLE;
        end
      endcase
    end
  end

  // PC, FSM state, parked redirect and request-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      state_r <= S_RUN;
      redir_r <= 32'h0000_0000;
      ren_r   <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      state_r <= state_nxt_s;
      redir_r <= redir_nxt_s;
      ren_r   <= 1'b1;
    end
  end

  // IF/ID pipeline register: load, bubble or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_inst_r  <= NOP_INST;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else begin
      case (ifid_op_s)
        OP_LOAD: begin
          ifid_inst_r  <= ICACHE_rdata;
          ifid_pc4_r   <= pc_seq_s;
          ifid_valid_r <= 1'b1;
        end
        OP_BUBBLE: begin
          ifid_inst_r  <= NOP_INST;
          ifid_pc4_r   <= 32'h0000_0000;
          ifid_valid_r <= 1'b0;
        end
        default: begin
          ifid_inst_r  <= ifid_inst_r;
          ifid_pc4_r   <= ifid_pc4_r;
          ifid_valid_r <= ifid_valid_r;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_r, perf_bubble_r;
  assign perf_fetch  = perf_fetch_r;
  assign perf_bubble = perf_bubble_r;

  // Count valid loads and bubble loads into IF/ID; held cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_r  <= 32'h0000_0000;
      perf_bubble_r <= 32'h0000_0000;
    end else begin
      if (ifid_op_s == OP_LOAD) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end else begin
        perf_fetch_r <= perf_fetch_r;
      end
      if (ifid_op_s == OP_BUBBLE) begin
        perf_bubble_r <= perf_bubble_r + 32'd1;
      end else begin
        perf_bubble_r <= perf_bubble_r;
      end
    end
  end
`endif

endmodule
